// File: rtl/key_onehot_capture.sv
// Key front end: two-flop synchroniser, per-key debounce and press detection,
// feeding a registered one-hot capture of the highest newly pressed key.
module key_onehot_capture #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 5
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iKey,
  input  logic       iClear,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oHeld,
  output logic [3:0] oCount
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       stable_q, stable_d;
  logic [7:0]       rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             held_q;
  logic [3:0]       count_q, count_d;

  // A level must disagree with the debounced state for DB_CYCLES
  // consecutive edges before it is accepted; any agreement restarts the run.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        rise_d[i]   = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A registered press beats a same-cycle clear; the highest index wins.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    count_d = count_q;
    if (rise_q != 8'h00) begin
      data_d = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (rise_q[i]) data_d = 8'h01 << i;
      end
      valid_d = 1'b1;
      count_d = count_q + 4'd1;
    end else if (iClear) begin
      data_d = 8'h00;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      sync1_q  <= iKey;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      data_q   <= data_d;
      valid_q  <= valid_d;
      held_q   <= |stable_d;
      count_q  <= count_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oHeld  = held_q;
  assign oCount = count_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Randomised and directed bench for key_onehot_capture against a
// window-based behavioural model of debounce and capture.
module tb_key_onehot_capture;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key = 8'h00;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       held;
  logic [3:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  key_onehot_capture #(.DB_CYCLES(DB), .CNT_W(5)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iKey   (key),
    .iClear (clr),
    .oData  (data),
    .oValid (valid),
    .oHeld  (held),
    .oCount (count)
  );

  // Model: raw history, synchronised-sample window, debounced state, capture.
  logic [7:0] raw_q [$];
  logic [7:0] syn_q [$];
  logic [7:0] m_stable, m_pend, m_data;
  logic       m_valid;
  logic [3:0] m_count;
  int         step_no;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, got, exp);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    syn_q.delete();
    m_stable = '0;
    m_pend   = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_count  = '0;
  endtask

  task automatic model_edge(input logic [7:0] raw, input logic c);
    logic [7:0] syn;
    logic [7:0] new_pend;
    int hi;
    bit all_diff;
    if (m_pend != 8'h00) begin
      hi = 0;
      for (int i = 0; i < 8; i++) if (m_pend[i]) hi = i;
      m_data  = 8'h01 << hi;
      m_valid = 1'b1;
      m_count = m_count + 4'd1;
    end else begin
      m_valid = 1'b0;
      if (c) m_data = 8'h00;
    end
    // The debouncer sees the raw level sampled two edges earlier.
    syn = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 8'h00;
    raw_q.push_back(raw);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    syn_q.push_back(syn);
    if (syn_q.size() > DB) void'(syn_q.pop_front());
    new_pend = '0;
    if (syn_q.size() == DB) begin
      for (int i = 0; i < 8; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (syn_q[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i]) new_pend[i] = 1'b1;
        end
      end
    end
    m_pend = new_pend;
  endtask

  task automatic step(input logic [7:0] k, input logic c);
    key = k;
    clr = c;
    @(posedge clk);
    model_edge(k, c);
    #1;
    step_no++;
    check_eq("data", data, m_data);
    check_eq("valid", valid, m_valid);
    check_eq("held", held, |m_stable);
    check_eq("count", count, m_count);
    check_eq("onehot", ($countones(data) <= 1), 1);
    if (valid) $display("[TB] step %0d press captured data=%02h count=%0d", step_no, data, count);
  endtask

  task automatic run(input logic [7:0] k, input logic c, input int n);
    for (int i = 0; i < n; i++) step(k, c);
  endtask

  // Applies k for n steps; returns the edge index (first edge = 0) of the first strobe.
  task automatic run_find(input logic [7:0] k, input int n, output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < n; i++) begin
      step(k, 1'b0);
      if (valid && edge_idx < 0) edge_idx = i;
    end
  endtask

  initial begin
    int e;
    logic [7:0] cur;
    step_no = 0;
    model_reset();
    #2;
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_held", held, 0);
    check_eq("rst_count", count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single press and release
    run_find(8'h04, 10, e);
    check_eq("p1_edge", e, 6);
    check_eq("p1_data", data, 8'h04);
    check_eq("p1_count", count, 1);
    check_eq("p1_held", held, 1);
    run(8'h00, 1'b0, 10);
    check_eq("rel_data", data, 8'h04);
    check_eq("rel_held", held, 0);

    // Short bounce never qualifies
    step(8'h08, 1'b0); step(8'h00, 1'b0); step(8'h08, 1'b0); step(8'h00, 1'b0);
    run(8'h00, 1'b0, 8);
    check_eq("bnc_data", data, 8'h04);
    check_eq("bnc_count", count, 1);

    // Simultaneous presses: highest wins, one increment
    run(8'h81, 1'b0, 10);
    check_eq("sim_data", data, 8'h80);
    check_eq("sim_count", count, 2);
    run(8'h01, 1'b0, 10);
    check_eq("sim_rel_count", count, 2);
    run(8'h00, 1'b0, 10);

    // Press coinciding with clear, then clear alone
    run(8'h20, 1'b0, 6);
    step(8'h20, 1'b1);
    check_eq("race_data", data, 8'h20);
    check_eq("race_valid", valid, 1);
    step(8'h20, 1'b1);
    check_eq("clr_data", data, 8'h00);
    check_eq("clr_count", count, 3);
    run(8'h00, 1'b0, 10);

    // Sixteen presses wrap the counter back to its start value
    for (int p = 0; p < 16; p++) begin
      run(8'h02, 1'b0, 8);
      run(8'h00, 1'b0, 8);
    end
    check_eq("wrap_count", count, 3);
    check_eq("wrap_data", data, 8'h02);

    // Reset while a key is mid-debounce
    run(8'h40, 1'b0, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_data", data, 8'h00);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_held", held, 0);
    check_eq("mid_rst_count", count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_find(8'h40, 10, e);
    check_eq("post_rst_edge", e, 6);
    check_eq("post_rst_data", data, 8'h40);
    run(8'h00, 1'b0, 10);

    // Random bouncing keys with occasional clears
    cur = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ (8'h01 << $urandom_range(0, 7));
      step(cur, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
